multiword_add_seq: RTL and testbench
====================================

// Module: multiword_add_seq
// PURPOSE
//  Sequencer that drives one shared W-bit adder to add NWORDS*W-bit operands, one W-bit word per cycle.
//  Chains the carry between words in a register, LSW first.
//  Sits between a requester (start/ready/done) and the W-bit adder datapath (add_* ports).
//  Multi-precision sums therefore need no wider adder hardware.
// PARAMETERS
//  W       16  word width of the shared adder
//  NWORDS  4   words per operand; total operand width N = W*NWORDS; NWORDS >= 2
// PORTS
//  clk       in   1    rising-edge clock
//  rst_n     in   1    asynchronous active-low reset
//  start     in   1    request; accepted only when ready=1
//  op_a      in   N    operand A, sampled on the accepting edge
//  op_b      in   N    operand B, sampled on the accepting edge
//  cin       in   1    carry into word 0, sampled on the accepting edge
//  sub       in   1    subtract select; port exists only with MWADD_SUB_EN
//  ready     out  1    1 in IDLE; start is accepted on this cycle's edge
//  done      out  1    one-cycle pulse; result and cout are valid
//  result    out  N    sum, held until the next accepted start
//  cout      out  1    carry out of the MSW, held with result
//  add_a     out  W    adder operand A (current word)
//  add_b     out  W    adder operand B (current word, inverted when subtracting)
//  add_cin   out  1    adder carry in (chained carry register)
//  add_sum   in   W    adder sum; combinational from add_a, add_b and add_cin in the same cycle
//  add_cout  in   1    adder carry out; combinational, same cycle
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE, idx=0, carry=0.
//   - ready=1, done=0, result=0, cout=0.
//   - add_a=0, add_b=0, add_cin=0.
//   - Reset mid-RUN aborts the operation immediately; no done pulse is produced.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE: ready=1. On start=1 at an edge:
//     latch op_a and op_b; carry<=cin; idx<=0; result<=0; cout<=0; go to RUN.
//   - RUN: add_a=A[idx*W+:W], add_b=B[idx*W+:W], add_cin=carry.
//     Each edge: result[idx*W+:W]<=add_sum; carry<=add_cout; idx<=idx+1.
//     The edge with idx=NWORDS-1 also sets cout<=add_cout and moves to DONE.
//   - DONE: done=1 for exactly one cycle; ready=0; next edge returns to IDLE.
//  Outside RUN, add_a, add_b and add_cin are driven to 0.
//  Latency: start accepted at edge T0; words are processed on edges T1..TNWORDS.
//   done=1 in the cycle after edge TNWORDS. Next start can be accepted on the edge ending the IDLE cycle.
//  start while in RUN or DONE is ignored and not queued; op_a, op_b and cin changes in RUN have no effect.
//  idx is $clog2(NWORDS) bits wide; it never wraps inside an operation and is reset to 0 on accept.
//  Arithmetic: result = (A + B + cin) mod 2^N; cout = bit N of that sum.
// CONFIGURATION
//  MWADD_SUB_EN defined:
//   - sub port exists and is latched on accept.
//   - sub=1: add_b = ~B word; initial carry = 1 (cin is ignored).
//   - Result = A - B mod 2^N; cout = 1 means no borrow (A >= B unsigned).
//   - sub=0: plain add, identical to the undefined case.
//  MWADD_SUB_EN undefined: no sub port; add-only; add_b = B word.
// TESTING (W=16, NWORDS=4)
//  1. Pulse rst_n=0 during RUN (idx=2) -> same cycle: ready=1, done=0, result=0, cout=0, add_*=0; no later done.
//  2. A=64'h0000_0000_0000_FFFF, B=1, cin=0 -> done 5 cycles after the start edge;
//     result=64'h0000_0000_0001_0000, cout=0; add_cin=1 in the word-1 cycle.
//  3. A=64'hFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> result=0, cout=1; carry ripples through all 4 words.
//  4. Hold start=1 continuously -> accepted only in IDLE cycles;
//     one operation per 6 cycles; operands changed mid-RUN do not alter result.
//  5. [MWADD_SUB_EN] A=64'h10, B=64'h20, sub=1 -> result=64'hFFFF_FFFF_FFFF_FFF0, cout=0;
//     A=64'h20, B=64'h10 -> result=64'h10, cout=1.
//  6. 1000 random A, B, cin (and sub) vs a behavioural N-bit model -> result and cout match on every done pulse.

Source files
------------

// File: rtl/multiword_add_seq.sv
// Multi-precision adder sequencer: feeds one shared W-bit adder a word per cycle, LSW first.
// Optional subtract mode is enabled with `define MWADD_SUB_EN.
module multiword_add_seq #(
  parameter  int W      = 16,
  parameter  int NWORDS = 4,
  localparam int N      = W * NWORDS,
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  input  logic         cin,
`ifdef MWADD_SUB_EN
  input  logic         sub,
`endif
  output logic         ready,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            binv_s;

`ifdef MWADD_SUB_EN
  logic            sub_q, sub_d;

  // Subtract select, captured with the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end

  assign binv_s = sub_q;
`else
  assign binv_s = 1'b0;
`endif

  // State, operand, carry and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // Next-state logic: accept in IDLE, one word per RUN cycle, single DONE cycle
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef MWADD_SUB_EN
    sub_d    = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = op_a;
          b_d      = op_b;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          state_d  = RUN;
`ifdef MWADD_SUB_EN
          sub_d    = sub;
          // Two's-complement subtract: invert B and inject the +1 as carry
          carry_d  = sub ? 1'b1 : cin;
`else
          carry_d  = cin;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d[idx_q*W +: W] = add_sum;
        carry_d                = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Adder operand mux; the shared adder sees zeros whenever it is not in use
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[idx_q*W +: W];
      add_b   = b_q[idx_q*W +: W] ^ {W{binv_s}};
      add_cin = carry_q;
    end else begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed and random checks of multiword_add_seq with a behavioural 16-bit adder attached.
module tb_multiword_add_seq;
  localparam int W      = 16;
  localparam int NWORDS = 4;
  localparam int N      = W * NWORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] op_a = '0;
  logic [N-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         ready, done, cout, add_cin, add_cout;
  logic [N-1:0] result;
  logic [W-1:0] add_a, add_b, add_sum;

  int n_checks = 0;
  int n_pass   = 0;

  multiword_add_seq #(.W(W), .NWORDS(NWORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef MWADD_SUB_EN
    .sub(sub),
`endif
    .ready(ready), .done(done), .result(result), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N:0] got, input logic [N:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic c, input logic s);
    if (s) model = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    else   model = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
  endfunction

  // One full operation: checks ready, exact done latency, result/cout; returns add_cin per word
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        input logic s, output logic [NWORDS-1:0] cins);
    logic [N:0] exp;
    exp = model(a, b, c, s);
    @(negedge clk);
    check("ready_idle", {{N{1'b0}}, ready}, {{N{1'b0}}, 1'b1});
    start = 1'b1; op_a = a; op_b = b; cin = c; sub = s;
    @(posedge clk);
    #1;
    start = 1'b0; op_a = ~a; op_b = ~b; cin = ~c; sub = ~s;
    for (int i = 0; i < NWORDS; i++) begin
      @(negedge clk);
      cins[i] = add_cin;
      if (i == NWORDS - 1) check("done_early", {{N{1'b0}}, done}, '0);
    end
    @(negedge clk);
    check("done_pulse", {{N{1'b0}}, done}, {{N{1'b0}}, 1'b1});
    check("result", {1'b0, result}, {1'b0, exp[N-1:0]});
    check("cout", {{N{1'b0}}, cout}, {{N{1'b0}}, exp[N]});
    sub = 1'b0;
  endtask

  logic [NWORDS-1:0] cins;
  logic [N-1:0]      ra, rb;
  logic              rc, rs;
  int                seen_done;

  initial begin
    // Reset state
    #2;
    check("rst_ready", {{N{1'b0}}, ready}, {{N{1'b0}}, 1'b1});
    check("rst_done", {{N{1'b0}}, done}, '0);
    check("rst_result", {cout, result}, '0);
    check("rst_add", {{(N-W-W){1'b0}}, add_a, add_b, add_cin}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 2: carry from word 0 into word 1
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, cins);
    check("t2_cins", {{(N+1-NWORDS){1'b0}}, cins}, {{(N+1-NWORDS){1'b0}}, 4'b0010});

    // Test 3: carry ripples through every word
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, cins);
    check("t3_cins", {{(N+1-NWORDS){1'b0}}, cins}, {{(N+1-NWORDS){1'b0}}, 4'b1111});
    check("t3_const", {cout, result}, {1'b1, 64'h0});

    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, cins);
    check("t_const", {1'b0, result}, {1'b0, 64'h2222_2222_2222_2211});

    // Test 1: reset while idx=2 aborts with no done
    @(negedge clk);
    start = 1'b1; op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'h1; cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", {{N{1'b0}}, ready}, {{N{1'b0}}, 1'b1});
    check("abort_done", {{N{1'b0}}, done}, '0);
    check("abort_result", {cout, result}, '0);
    check("abort_add", {{(N-W-W){1'b0}}, add_a, add_b, add_cin}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort_no_done", N'(seen_done), '0);

    // Test 4: start held high; operands scrambled while busy
    @(negedge clk);
    start = 1'b1;
    for (int op = 0; op < 3; op++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'($urandom);
      if (op > 0) @(negedge clk);
      check("hold_ready", {{N{1'b0}}, ready}, {{N{1'b0}}, 1'b1});
      op_a = ra; op_b = rb; cin = rc;
      @(posedge clk);
      for (int k = 0; k < 5; k++) begin
        #1;
        op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; cin = 1'($urandom);
        @(negedge clk);
        check("hold_busy", {{N{1'b0}}, ready}, '0);
        check("hold_done", {{N{1'b0}}, done}, {{N{1'b0}}, (k == 4)});
        if (k == 4) check("hold_sum", {cout, result}, model(ra, rb, rc, 1'b0));
        if (k < 4) @(posedge clk);
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);

`ifdef MWADD_SUB_EN
    // Test 5: subtract with and without borrow
    run_op(64'h10, 64'h20, 1'b0, 1'b1, cins);
    check("sub_borrow", {cout, result}, {1'b0, 64'hFFFF_FFFF_FFFF_FFF0});
    run_op(64'h20, 64'h10, 1'b1, 1'b1, cins);
    check("sub_noborrow", {cout, result}, {1'b1, 64'h10});
`endif

    // Test 6: random operands against the behavioural model
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'($urandom);
`ifdef MWADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (i % 8 == 0) rb = ~ra;
      run_op(ra, rb, rc, rs, cins);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
